// File: rtl/lfsr_hash_engine.sv
// LFSR hash generator for the LZW dictionary lookup path.
// Loads a length-masked key, shifts a fixed number of cycles, and supports re-probing on collision.
module lfsr_hash_engine #(
    parameter int HASH_WIDTH    = 11,
    parameter int KEY_BYTES     = 8,
    parameter int SHIFT_CYCLES  = 8,
    parameter int REHASH_CYCLES = 1,
    parameter int MAX_PROBES    = 4,
    localparam int PROBE_W      = (MAX_PROBES > 1) ? $clog2(MAX_PROBES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] data_in,
    input  logic [2:0]             num_char,
    output logic                   busy,
    output logic [HASH_WIDTH-1:0]  hash_out,
    output logic                   hash_valid,
    input  logic                   hash_ready,
    input  logic                   rehash,
    output logic [PROBE_W-1:0]     probe_idx,
    output logic                   probe_exhausted
);

    // state | meaning
    // IDLE  | waiting for start
    // SHIFT | shifting the LFSR, count_q shifts remaining
    // DONE  | hash_out valid, waiting for consumer handshake
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0]         MAX_LEN     = 3'(KEY_BYTES - 1);
    localparam logic [7:0]         SHIFT_INIT  = 8'(SHIFT_CYCLES);
    localparam logic [7:0]         REHASH_INIT = 8'(REHASH_CYCLES);
    localparam logic [PROBE_W-1:0] LAST_PROBE  = PROBE_W'(MAX_PROBES - 1);

    state_t               state_q;
    logic [63:0]          shift_reg_q;
    logic [7:0]           count_q;
    logic [2:0]           len_q;
    logic [PROBE_W-1:0]   probe_idx_q;
    logic                 exhausted_q;

    logic [2:0]           len_d;
    logic [63:0]          load_d;
    logic                 fb;

    always_comb begin
        len_d = (num_char > MAX_LEN) ? MAX_LEN : num_char;
    end

    // Bytes above the key length are zeroed; bits above the key port are zero by extension.
    always_comb begin
        load_d = 64'(data_in);
        for (int b = 0; b < 8; b++) begin
            if (3'(b) > len_d) begin
                load_d[8*b +: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        case (len_q)
            3'd0:    fb = ~(shift_reg_q[7]  ^ shift_reg_q[5]  ^ shift_reg_q[4]  ^ shift_reg_q[3]);
            3'd1:    fb = ~(shift_reg_q[15] ^ shift_reg_q[13] ^ shift_reg_q[12] ^ shift_reg_q[10]);
            3'd2:    fb = ~(shift_reg_q[23] ^ shift_reg_q[22] ^ shift_reg_q[20] ^ shift_reg_q[19]);
            3'd3:    fb = ~(shift_reg_q[31] ^ shift_reg_q[29] ^ shift_reg_q[25] ^ shift_reg_q[24]);
            3'd4:    fb = ~(shift_reg_q[39] ^ shift_reg_q[36] ^ shift_reg_q[35] ^ shift_reg_q[34]);
            3'd5:    fb = ~(shift_reg_q[47] ^ shift_reg_q[43] ^ shift_reg_q[40] ^ shift_reg_q[38]);
            3'd6:    fb = ~(shift_reg_q[55] ^ shift_reg_q[53] ^ shift_reg_q[51] ^ shift_reg_q[48]);
            default: fb = ~(shift_reg_q[63] ^ shift_reg_q[62] ^ shift_reg_q[60] ^ shift_reg_q[59]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            count_q     <= '0;
            len_q       <= '0;
            probe_idx_q <= '0;
            exhausted_q <= 1'b0;
        end else begin
            exhausted_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_reg_q <= load_d;
                        len_q       <= len_d;
                        probe_idx_q <= '0;
                        if (SHIFT_CYCLES == 0) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= SHIFT_INIT;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg_q <= {shift_reg_q[62:0], fb};
                    count_q     <= count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (hash_ready) begin
                        if (!rehash) begin
                            state_q <= IDLE;
                        end else if (probe_idx_q == LAST_PROBE) begin
                            exhausted_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            probe_idx_q <= probe_idx_q + PROBE_W'(1);
                            count_q     <= REHASH_INIT;
                            state_q     <= SHIFT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign hash_valid      = (state_q == DONE);
    assign hash_out        = shift_reg_q[HASH_WIDTH-1:0];
    assign probe_idx       = probe_idx_q;
    assign probe_exhausted = exhausted_q;

endmodule

// File: tb/tb_lfsr_hash_engine.sv
// Bench for lfsr_hash_engine: default instance plus a 2-byte/64-bit-hash instance, checked
// against a behavioural key-load and LFSR model.
module tb_lfsr_hash_engine;

    localparam int HW  = 11, SC  = 8, RC  = 1, MP  = 4;
    localparam int HW2 = 64, KB2 = 2, SC2 = 3, RC2 = 2, MP2 = 2;
    localparam logic [63:0] HMASK = (64'd1 << HW) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, hash_ready, rehash;
    logic [63:0] data_in;
    logic [2:0]  num_char;
    logic        busy, hash_valid, probe_exhausted;
    logic [HW-1:0] hash_out;
    logic [1:0]  probe_idx;

    logic        start2, ready2, rehash2;
    logic [15:0] data2;
    logic [2:0]  nc2;
    logic        busy2, valid2, exh2;
    logic [63:0] hash2;
    logic [0:0]  probe2;

    int nchk = 0;
    int nfail = 0;

    int taps [8][4] = '{'{7,5,4,3}, '{15,13,12,10}, '{23,22,20,19}, '{31,29,25,24},
                        '{39,36,35,34}, '{47,43,40,38}, '{55,53,51,48}, '{63,62,60,59}};
    logic [63:0] seq [8] = '{64'h1, 64'h3, 64'h7, 64'hF, 64'h1E, 64'h3D, 64'h7A, 64'hF4};

    lfsr_hash_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .num_char(num_char),
        .busy(busy), .hash_out(hash_out), .hash_valid(hash_valid), .hash_ready(hash_ready),
        .rehash(rehash), .probe_idx(probe_idx), .probe_exhausted(probe_exhausted)
    );

    lfsr_hash_engine #(.HASH_WIDTH(HW2), .KEY_BYTES(KB2), .SHIFT_CYCLES(SC2),
                       .REHASH_CYCLES(RC2), .MAX_PROBES(MP2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_in(data2), .num_char(nc2),
        .busy(busy2), .hash_out(hash2), .hash_valid(valid2), .hash_ready(ready2),
        .rehash(rehash2), .probe_idx(probe2), .probe_exhausted(exh2)
    );

    // Key loaded with bytes 0..len kept, then nsh feedback shifts with the length's taps.
    function automatic logic [63:0] model(input logic [63:0] d, input int nc, input int kb, input int nsh);
        int len;
        logic [63:0] s;
        logic f;
        len = (nc > kb - 1) ? kb - 1 : nc;
        s = '0;
        for (int b = 0; b <= len; b++) s[8*b +: 8] = d[8*b +: 8];
        for (int i = 0; i < nsh; i++) begin
            f = ~(s[taps[len][0]] ^ s[taps[len][1]] ^ s[taps[len][2]] ^ s[taps[len][3]]);
            s = {s[62:0], f};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] d, input logic [2:0] nc);
        @(negedge clk);
        start = 1'b1; data_in = d; num_char = nc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One key on the default instance: nreh rehash requests (nreh == MP forces exhaustion).
    task automatic run_key(input logic [63:0] d, input logic [2:0] nc, input int nreh, input int bp);
        int e, total;
        logic [63:0] m;
        logic rh;
        do_start(d, nc);
        total = 0;
        for (int p = 0; p < MP; p++) begin
            e = 1;
            while (!hash_valid && e < 300) begin
                m = model(d, nc, 8, total + e - 1);
                chk("shift_step", hash_out, m & HMASK);
                start = 1'($urandom_range(0, 1));
                data_in = {$urandom, $urandom};
                num_char = 3'($urandom);
                @(negedge clk);
                e++;
            end
            start = 1'b0;
            total += (p == 0) ? SC : RC;
            chk("latency", e, 1 + ((p == 0) ? SC : RC));
            m = model(d, nc, 8, total);
            chk("hash", hash_out, m & HMASK);
            chk("probe_idx", probe_idx, p);
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                chk("bp_hold", hash_out, m & HMASK);
                chk("bp_valid", hash_valid, 1);
            end
            rh = (p < nreh);
            hash_ready = 1'b1; rehash = rh; start = 1'b1;
            @(negedge clk);
            hash_ready = 1'b0; rehash = 1'b0; start = 1'b0;
            if (!rh) begin
                chk("idle_busy", busy, 0);
                chk("idle_valid", hash_valid, 0);
                chk("idle_exh", probe_exhausted, 0);
                break;
            end else if (p == MP - 1) begin
                chk("exh_pulse", probe_exhausted, 1);
                chk("exh_busy", busy, 0);
                @(negedge clk);
                chk("exh_clear", probe_exhausted, 0);
                break;
            end else begin
                chk("reprobe_idx", probe_idx, p + 1);
                chk("reprobe_valid", hash_valid, 0);
                chk("reprobe_exh", probe_exhausted, 0);
            end
        end
    endtask

    task automatic run_key2(input logic [15:0] d, input logic [2:0] nc, input int nreh);
        int e, total;
        logic rh;
        @(negedge clk);
        start2 = 1'b1; data2 = d; nc2 = nc;
        @(negedge clk);
        total = 0;
        for (int p = 0; p < MP2; p++) begin
            e = 1;
            while (!valid2 && e < 300) begin
                start2 = 1'b1;
                data2 = 16'($urandom);
                @(negedge clk);
                e++;
            end
            start2 = 1'b0;
            total += (p == 0) ? SC2 : RC2;
            chk("d2_latency", e, 1 + ((p == 0) ? SC2 : RC2));
            chk("d2_hash", hash2, model({48'b0, d}, nc, KB2, total));
            chk("d2_probe", probe2, p);
            rh = (p < nreh);
            ready2 = 1'b1; rehash2 = rh;
            @(negedge clk);
            ready2 = 1'b0; rehash2 = 1'b0;
            if (!rh) begin
                chk("d2_idle", busy2, 0);
                break;
            end else if (p == MP2 - 1) begin
                chk("d2_exh", exh2, 1);
                chk("d2_exh_busy", busy2, 0);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; hash_ready = 1'b0; rehash = 1'b0; data_in = '0; num_char = '0;
        start2 = 1'b0; ready2 = 1'b0; rehash2 = 1'b0; data2 = '0; nc2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", hash_valid, 0);
        chk("rst_hash", hash_out, 0);
        chk("rst_exh", probe_exhausted, 0);
        chk("rst2_hash", hash2, 0);
        rst = 1'b1;

        // Reset in the middle of a shift sequence.
        do_start(64'h0123_4567_89AB_CDEF, 3'd3);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", hash_valid, 0);
        chk("mid_rst_hash", hash_out, 0);
        chk("mid_rst_probe", probe_idx, 0);
        rst = 1'b1;

        // Known sequence for a zero one-byte key, backpressure, then one re-probe.
        do_start(64'h0, 3'd0);
        chk("t2_load", hash_out, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_shift", hash_out, seq[i]);
            chk("t2_valid", hash_valid, (i == 7) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold", hash_out, 64'h0F4);
            chk("t3_valid", hash_valid, 1);
        end
        hash_ready = 1'b1; rehash = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0; rehash = 1'b0;
        chk("t4_probe", probe_idx, 1);
        chk("t4_valid0", hash_valid, 0);
        @(negedge clk);
        chk("t4_valid1", hash_valid, 1);
        chk("t4_hash", hash_out, 64'h1E8);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        chk("t4_idle", busy, 0);

        // Full probe exhaustion, then a two-byte all-ones key.
        run_key(64'h0, 3'd0, MP, 0);
        run_key(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1, 2);
        do_start(64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        chk("t6_load", hash_out, 64'h7FF);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 24; n++) begin
            run_key({$urandom, $urandom}, 3'($urandom), $urandom_range(0, MP), $urandom_range(0, 3));
        end

        // Narrow-key instance: full 64-bit state visible, num_char clamped to one.
        run_key2(16'hFFFF, 3'd7, MP2);
        run_key2(16'hFFFF, 3'd0, 0);
        run_key2(16'hFFFF, 3'd1, 1);
        for (int n = 0; n < 8; n++) begin
            run_key2(16'($urandom), 3'($urandom), $urandom_range(0, MP2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
